// File: rtl/sched_pkg.sv
// sched_pkg: shared types and constants for the execution scheduler.
//   op_e        - request opcode encoding (req_op)
//   state_e     - scheduler FSM states
//   UNIT_*      - bit positions of each unit in unit_start / unit_done
//   op_start_mask() - one-hot unit_start pattern for an opcode
package sched_pkg;

    localparam int DATA_W    = 32;
    localparam int RD_W      = 5;
    localparam int CNT_W     = 16;
    localparam int WDOG_W    = 8;
    localparam int NUM_UNITS = 3;

    localparam int UNIT_MULHSU = 0;
    localparam int UNIT_LUI    = 1;
    localparam int UNIT_MUL    = 2;

    typedef enum logic [1:0] {
        OP_MULHSU = 2'd0,
        OP_LUI    = 2'd1,
        OP_MUL    = 2'd2,
        OP_RSVD   = 2'd3
    } op_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_e;

    // Reserved ops map to an all-zero mask so no unit is ever started.
    function automatic logic [NUM_UNITS-1:0] op_start_mask(input op_e op);
        logic [NUM_UNITS-1:0] mask;
        mask = '0;
        case (op)
            OP_MULHSU: mask[UNIT_MULHSU] = 1'b1;
            OP_LUI:    mask[UNIT_LUI]    = 1'b1;
            OP_MUL:    mask[UNIT_MUL]    = 1'b1;
            default:   mask              = '0;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/sched_watchdog.sv
// sched_watchdog: counts cycles spent waiting for a unit to finish.
//   clk     - clock
//   rst     - synchronous active-high reset
//   enable  - count this cycle (scheduler is in WAIT)
//   clear   - return the count to zero (scheduler is outside WAIT)
//   expired - count has reached TIMEOUT-1
module sched_watchdog
    import sched_pkg::*;
#(
    parameter int TIMEOUT = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    input  logic clear,
    output logic expired
);

    localparam logic [WDOG_W-1:0] LIMIT = WDOG_W'(TIMEOUT - 1);

    logic [WDOG_W-1:0] count_q;

    // NOTE: sequential state is always written with non-blocking assignments so
    // every flop samples values from before the edge, regardless of block order.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else if (clear) begin
            count_q <= '0;
        end else if (enable && !expired) begin
            count_q <= count_q + WDOG_W'(1);
        end
    end

    // Depends only on the register, never on enable, so the FSM can use it
    // in the same combinational block that produces enable.
    assign expired = (count_q == LIMIT);

endmodule

// File: rtl/exec_scheduler.sv
// exec_scheduler: accepts one operation at a time, starts the matching
// execution unit, waits (with a watchdog) for its done flag and returns the
// result through a valid/ready response channel.
//   clk, rst                 - clock, synchronous active-high reset
//   req_valid/req_ready      - request handshake
//   req_op, req_x, req_y     - opcode and operands
//   req_rd                   - destination tag echoed on rsp_rd
//   unit_start               - one-hot start pulse (0=mulhsu, 1=lui, 2=mul)
//   unit_x, unit_y           - latched operands shared by all units
//   unit_done, unit_res0..2  - per-unit completion flags and results
//   unit_clear               - one-cycle unit reset after a timeout
//   rsp_valid/rsp_ready      - response handshake
//   rsp_result, rsp_rd, rsp_err - response payload
//   busy                     - FSM not in IDLE
//   op_count                 - completed responses, wrapping
module exec_scheduler
    import sched_pkg::*;
#(
    parameter int TIMEOUT = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [1:0]           req_op,
    input  logic [DATA_W-1:0]    req_x,
    input  logic [DATA_W-1:0]    req_y,
    input  logic [RD_W-1:0]      req_rd,
    output logic [NUM_UNITS-1:0] unit_start,
    output logic [DATA_W-1:0]    unit_x,
    output logic [DATA_W-1:0]    unit_y,
    input  logic [NUM_UNITS-1:0] unit_done,
    input  logic [DATA_W-1:0]    unit_res0,
    input  logic [DATA_W-1:0]    unit_res1,
    input  logic [DATA_W-1:0]    unit_res2,
    output logic                 unit_clear,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [DATA_W-1:0]    rsp_result,
    output logic [RD_W-1:0]      rsp_rd,
    output logic                 rsp_err,
    output logic                 busy,
    output logic [CNT_W-1:0]     op_count
);

    state_e            state_q, state_d;
    op_e               op_q;
    op_e               req_op_e;
    logic [CNT_W-1:0]  op_count_q;

    logic              sel_done;
    logic [DATA_W-1:0] sel_res;
    logic              done_hit;
    logic              timeout_hit;
    logic              accept;
    logic              wd_enable;
    logic              wd_clear;
    logic              wd_expired;

    assign req_op_e = op_e'(req_op);

    sched_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk     (clk),
        .rst     (rst),
        .enable  (wd_enable),
        .clear   (wd_clear),
        .expired (wd_expired)
    );

    // Only the unit selected by the latched op is looked at; stray done bits
    // from the other units never reach the FSM.
    always_comb begin
        sel_done = 1'b0;
        sel_res  = '0;
        case (op_q)
            OP_MULHSU: begin sel_done = unit_done[UNIT_MULHSU]; sel_res = unit_res0; end
            OP_LUI:    begin sel_done = unit_done[UNIT_LUI];    sel_res = unit_res1; end
            OP_MUL:    begin sel_done = unit_done[UNIT_MUL];    sel_res = unit_res2; end
            default:   begin sel_done = 1'b0;                   sel_res = '0;        end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: every signal written here gets a default first, so no path through
    // the case statement leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d     = state_q;
        req_ready   = 1'b0;
        accept      = 1'b0;
        unit_start  = '0;
        wd_enable   = 1'b0;
        wd_clear    = 1'b1;
        done_hit    = 1'b0;
        timeout_hit = 1'b0;
        case (state_q)
            IDLE: begin
                // Held low while rst is asserted, even before the state settles.
                req_ready = !rst;
                accept    = req_valid && !rst;
                if (accept) begin
                    state_d = (req_op_e == OP_RSVD) ? RESP : ISSUE;
                end
            end
            ISSUE: begin
                unit_start = op_start_mask(op_q);
                state_d    = WAIT;
            end
            WAIT: begin
                wd_enable = 1'b1;
                wd_clear  = 1'b0;
                if (sel_done) begin
                    done_hit = 1'b1;
                    state_d  = RESP;
                end else if (wd_expired) begin
                    timeout_hit = 1'b1;
                    state_d     = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op_q       <= OP_MULHSU;
            unit_x     <= '0;
            unit_y     <= '0;
            rsp_rd     <= '0;
            rsp_result <= '0;
            rsp_err    <= 1'b0;
            unit_clear <= 1'b0;
            op_count_q <= '0;
        end else begin
            // Registered so the pulse lands in the first RESP cycle.
            unit_clear <= timeout_hit;

            if (accept) begin
                op_q       <= req_op_e;
                unit_x     <= req_x;
                unit_y     <= req_y;
                rsp_rd     <= req_rd;
                rsp_result <= '0;
                rsp_err    <= (req_op_e == OP_RSVD);
            end

            if (done_hit) begin
                rsp_result <= sel_res;
                rsp_err    <= 1'b0;
            end else if (timeout_hit) begin
                rsp_result <= '0;
                rsp_err    <= 1'b1;
            end

            if (rsp_valid && rsp_ready) begin
                op_count_q <= op_count_q + CNT_W'(1);
            end
        end
    end

    assign rsp_valid = (state_q == RESP);
    assign busy      = (state_q != IDLE);
    assign op_count  = op_count_q;

endmodule

// File: tb/tb_exec_scheduler.sv
// tb_exec_scheduler: directed self-checking bench for exec_scheduler
// (TIMEOUT=8). Inputs change 1 time unit after each rising edge and outputs
// are sampled at the same point.
module tb_exec_scheduler;

    localparam int TIMEOUT = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_op;
    logic [31:0] req_x;
    logic [31:0] req_y;
    logic [4:0]  req_rd;
    logic [2:0]  unit_start;
    logic [31:0] unit_x;
    logic [31:0] unit_y;
    logic [2:0]  unit_done;
    logic [31:0] unit_res0;
    logic [31:0] unit_res1;
    logic [31:0] unit_res2;
    logic        unit_clear;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_result;
    logic [4:0]  rsp_rd;
    logic        rsp_err;
    logic        busy;
    logic [15:0] op_count;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    exec_scheduler #(
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_x      (req_x),
        .req_y      (req_y),
        .req_rd     (req_rd),
        .unit_start (unit_start),
        .unit_x     (unit_x),
        .unit_y     (unit_y),
        .unit_done  (unit_done),
        .unit_res0  (unit_res0),
        .unit_res1  (unit_res1),
        .unit_res2  (unit_res2),
        .unit_clear (unit_clear),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_result (rsp_result),
        .rsp_rd     (rsp_rd),
        .rsp_err    (rsp_err),
        .busy       (busy),
        .op_count   (op_count)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents one request in the current (IDLE) cycle and steps past the
    // accepting edge; returns in cycle N+1.
    task automatic send(input logic [1:0] op, input logic [31:0] x,
                        input logic [31:0] y, input logic [4:0] rd);
        req_valid = 1'b1;
        req_op    = op;
        req_x     = x;
        req_y     = y;
        req_rd    = rd;
        check("req_ready_idle", 32'(req_ready), 32'd1);
        tick();
        req_valid = 1'b0;
    endtask

    task automatic handshake(input logic [15:0] exp_count);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check("op_count", 32'(op_count), 32'(exp_count));
        check("req_ready_after", 32'(req_ready), 32'd1);
    endtask

    initial begin
        int waited;
        int clears;

        rst = 1'b1; req_valid = 1'b0; req_op = 2'd0; req_x = '0; req_y = '0; req_rd = '0;
        unit_done = '0; unit_res0 = '0; unit_res1 = '0; unit_res2 = '0; rsp_ready = 1'b0;
        tick();
        tick();

        // Reset state
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_op_count", 32'(op_count), 32'd0);
        check("rst_unit_start", 32'(unit_start), 32'd0);
        rst = 1'b0;
        tick();
        check("idle_req_ready", 32'(req_ready), 32'd1);

        // MUL 7*6, done on first WAIT cycle -> response at N+3
        send(2'd2, 32'd7, 32'd6, 5'd3);
        check("mul_start_issue", 32'(unit_start), 32'b100);
        check("mul_unit_x", unit_x, 32'd7);
        check("mul_unit_y", unit_y, 32'd6);
        check("mul_busy", 32'(busy), 32'd1);
        check("mul_req_ready_issue", 32'(req_ready), 32'd0);
        tick();
        check("mul_start_wait", 32'(unit_start), 32'b000);
        check("mul_valid_wait", 32'(rsp_valid), 32'd0);
        unit_done = 3'b100;
        unit_res2 = 32'd42;
        tick();
        unit_done = '0;
        check("mul_valid_n3", 32'(rsp_valid), 32'd1);
        check("mul_result", rsp_result, 32'd42);
        check("mul_err", 32'(rsp_err), 32'd0);
        check("mul_rd", 32'(rsp_rd), 32'd3);
        handshake(16'd1);

        // LUI with spurious done[0] and done[2] held throughout
        unit_done = 3'b101;
        unit_res0 = 32'hDEAD0000;
        unit_res1 = 32'h12345000;
        unit_res2 = 32'hBEEF0000;
        send(2'd1, 32'h00012345, 32'd0, 5'd5);
        check("lui_start", 32'(unit_start), 32'b010);
        tick();
        for (int i = 0; i < 3; i++) begin
            check("lui_no_early_rsp", 32'(rsp_valid), 32'd0);
            tick();
        end
        unit_done = 3'b111;
        tick();
        unit_done = '0;
        check("lui_valid", 32'(rsp_valid), 32'd1);
        check("lui_result", rsp_result, 32'h12345000);
        check("lui_rd", 32'(rsp_rd), 32'd5);
        check("lui_err", 32'(rsp_err), 32'd0);
        handshake(16'd2);

        // MULHSU timeout: 8 WAIT cycles, then RESP with err and one clear pulse
        send(2'd0, 32'hFFFFFFFF, 32'd2, 5'd17);
        check("hsu_start", 32'(unit_start), 32'b001);
        tick();
        waited = 0;
        clears = 0;
        while (!rsp_valid && waited < 20) begin
            clears += int'(unit_clear);
            tick();
            waited++;
        end
        check("to_wait_cycles", 32'(waited), 32'd8);
        check("to_no_early_clear", 32'(clears), 32'd0);
        check("to_clear_pulse", 32'(unit_clear), 32'd1);
        check("to_err", 32'(rsp_err), 32'd1);
        check("to_result", rsp_result, 32'd0);
        check("to_rd", 32'(rsp_rd), 32'd17);
        handshake(16'd3);
        check("to_clear_single", 32'(unit_clear), 32'd0);

        // Reserved op: no start, error response at N+1
        send(2'd3, 32'd1, 32'd1, 5'd8);
        check("rsvd_no_start", 32'(unit_start), 32'b000);
        check("rsvd_valid_n1", 32'(rsp_valid), 32'd1);
        check("rsvd_err", 32'(rsp_err), 32'd1);
        check("rsvd_result", rsp_result, 32'd0);
        handshake(16'd4);

        // Reset in the middle of WAIT
        send(2'd2, 32'd11, 32'd13, 5'd21);
        tick();
        tick();
        rst = 1'b1;
        tick();
        check("mrst_req_ready", 32'(req_ready), 32'd0);
        check("mrst_unit_start", 32'(unit_start), 32'd0);
        check("mrst_unit_clear", 32'(unit_clear), 32'd0);
        check("mrst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("mrst_rsp_err", 32'(rsp_err), 32'd0);
        check("mrst_rsp_result", rsp_result, 32'd0);
        check("mrst_rsp_rd", 32'(rsp_rd), 32'd0);
        check("mrst_unit_x", unit_x, 32'd0);
        check("mrst_unit_y", unit_y, 32'd0);
        check("mrst_op_count", 32'(op_count), 32'd0);
        check("mrst_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        unit_done = 3'b111;
        clears = 0;
        waited = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            clears += int'(unit_clear);
            waited += int'(rsp_valid);
        end
        unit_done = '0;
        check("mrst_no_response", 32'(waited), 32'd0);
        check("mrst_no_clear", 32'(clears), 32'd0);
        check("mrst_idle", 32'(req_ready), 32'd1);

        // Backpressure with counter near wrap
        dut.op_count_q = 16'hFFFE;
        send(2'd2, 32'd3, 32'd5, 5'd9);
        tick();
        unit_done = 3'b100;
        unit_res2 = 32'd15;
        tick();
        unit_done = 3'b100;
        unit_res2 = 32'd99;
        req_valid = 1'b1;
        req_op    = 2'd1;
        for (int i = 0; i < 10; i++) begin
            check("bp_valid", 32'(rsp_valid), 32'd1);
            check("bp_result", rsp_result, 32'd15);
            check("bp_rd", 32'(rsp_rd), 32'd9);
            check("bp_err", 32'(rsp_err), 32'd0);
            check("bp_req_ready", 32'(req_ready), 32'd0);
            check("bp_unit_x", unit_x, 32'd3);
            check("bp_unit_y", unit_y, 32'd5);
            tick();
        end
        req_valid = 1'b0;
        unit_done = '0;
        handshake(16'hFFFF);
        check("bp_no_accept", 32'(busy), 32'd0);

        send(2'd3, 32'd0, 32'd0, 5'd1);
        check("wrap_valid", 32'(rsp_valid), 32'd1);
        handshake(16'h0000);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
